packet_assembler: RTL and testbench

- Transmit-side counterpart of the payload aligner. It takes a parsed packet (headers A/B/C plus a lane-0-aligned payload stream) and serialises it back onto the packet stream format (valid/data/sop/eop/byte_enable).
- Headers are prepended, so payload bytes are shifted by HDR_BYTES lanes across beat boundaries.
- Sits between payload-producing logic and the packet link. A one-beat flush stalls the upstream source when the header offset spills into an extra output beat.

---
 rtl/packet_assembler.sv | 165 ++++++++++++++++
 tb/tb_packet_assembler.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/packet_assembler.sv
// Serialises a parsed packet (headers A/B/C plus a lane-0-aligned payload) back onto
// the packet stream, prepending the headers and flushing any spilled residue in one extra beat.
module packet_assembler #(
    parameter int PACKET_WIDTH_BYTES = 8,
    parameter int HDR_A_BYTES        = 2,
    parameter int HDR_B_BYTES        = 4,
    parameter int HDR_C_BYTES        = 1
) (
    input  logic                                                    iClk,
    input  logic                                                    iReset_n,
    input  logic [8*(HDR_A_BYTES+HDR_B_BYTES+HDR_C_BYTES)-1:0]      iHeaders,
    input  logic [8*PACKET_WIDTH_BYTES-1:0]                         iPayload,
    input  logic                                                    iPayload_valid,
    input  logic                                                    iSop,
    input  logic                                                    iEop,
    input  logic [PACKET_WIDTH_BYTES-1:0]                           iByte_enable,
    output logic                                                    oPayload_ready,
    output logic                                                    oValid,
    output logic [8*PACKET_WIDTH_BYTES-1:0]                         oPacket,
    output logic                                                    oSop,
    output logic                                                    oEop,
    output logic [PACKET_WIDTH_BYTES-1:0]                           oByte_enable,
    output logic                                                    oError
);

    localparam int W  = PACKET_WIDTH_BYTES;
    localparam int HB = HDR_A_BYTES + HDR_B_BYTES + HDR_C_BYTES;
    localparam int DW = 8 * W;
    localparam int HW = 8 * HB;
    localparam int CW = $clog2(2 * W + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BODY,
        ST_TAIL
    } state_t;

    function automatic logic [CW-1:0] lead_ones(input logic [W-1:0] be);
        logic          run;
        logic [CW-1:0] n;
        run = 1'b1;
        n   = '0;
        for (int i = W - 1; i >= 0; i--) begin
            run = run & be[i];
            n   = n + CW'(run);
        end
        return n;
    endfunction

    function automatic logic [W-1:0] top_lanes(input logic [CW-1:0] k);
        return ~({W{1'b1}} >> k);
    endfunction

    function automatic logic [DW-1:0] lane_bits(input logic [W-1:0] be);
        logic [DW-1:0] bits;
        for (int i = 0; i < W; i++) begin
            bits[8*i +: 8] = {8{be[i]}};
        end
        return bits;
    endfunction

    state_t        state_q;
    logic [HW-1:0] resid_q;
    logic [W-1:0]  tail_mask_q;
    logic          ready_q;
    logic          valid_q;
    logic [DW-1:0] packet_q;
    logic          sop_q;
    logic          eop_q;
    logic [W-1:0]  be_q;
    logic          error_q;

    logic          accept;
    logic          be_zero;
    logic [CW-1:0] n_eff;
    logic [CW-1:0] sum;
    logic          fits;
    logic [DW-1:0] beat;
    logic [W-1:0]  eop_mask;
    logic [W-1:0]  tail_mask;

    // NOTE: every signal gets a default at the top of always_comb so no latch is inferred.
    always_comb begin
        accept    = iPayload_valid && ready_q;
        be_zero   = (iByte_enable == '0);
        n_eff     = be_zero ? CW'(1) : lead_ones(iByte_enable);
        sum       = CW'(HB) + n_eff;
        fits      = (sum <= CW'(W));
        beat      = {(iSop ? iHeaders : resid_q), iPayload[DW-1:HW]};
        eop_mask  = top_lanes(sum);
        tail_mask = top_lanes(sum - CW'(W));
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge iClk) begin
        if (!iReset_n) begin
            state_q     <= ST_IDLE;
            resid_q     <= '0;
            tail_mask_q <= '0;
            ready_q     <= 1'b0;
            valid_q     <= 1'b0;
            packet_q    <= '0;
            sop_q       <= 1'b0;
            eop_q       <= 1'b0;
            be_q        <= '0;
            error_q     <= 1'b0;
        end else begin
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            packet_q <= '0;
            sop_q    <= 1'b0;
            eop_q    <= 1'b0;
            be_q     <= '0;
            error_q  <= 1'b0;
            case (state_q)
                ST_TAIL: begin
                    valid_q  <= 1'b1;
                    eop_q    <= 1'b1;
                    be_q     <= tail_mask_q;
                    packet_q <= {resid_q, {(DW-HW){1'b0}}} & lane_bits(tail_mask_q);
                    state_q  <= ST_IDLE;
                end
                default: begin
                    if (accept) begin
                        if (!iSop && state_q == ST_IDLE) begin
                            // Stray continuation beat with no open packet: drop it.
                            error_q <= 1'b1;
                        end else begin
                            error_q <= (iSop && state_q == ST_BODY) || (iEop && be_zero);
                            resid_q <= iPayload[HW-1:0];
                            valid_q <= 1'b1;
                            sop_q   <= iSop;
                            if (iEop && fits) begin
                                eop_q    <= 1'b1;
                                be_q     <= eop_mask;
                                packet_q <= beat & lane_bits(eop_mask);
                                state_q  <= ST_IDLE;
                            end else if (iEop) begin
                                // Header offset spills the last bytes into a flush beat.
                                be_q        <= '1;
                                packet_q    <= beat;
                                tail_mask_q <= tail_mask;
                                ready_q     <= 1'b0;
                                state_q     <= ST_TAIL;
                            end else begin
                                be_q     <= '1;
                                packet_q <= beat;
                                state_q  <= ST_BODY;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign oPayload_ready = ready_q;
    assign oValid         = valid_q;
    assign oPacket        = packet_q;
    assign oSop           = sop_q;
    assign oEop           = eop_q;
    assign oByte_enable   = be_q;
    assign oError         = error_q;

endmodule

// File: tb/tb_packet_assembler.sv
// Directed bench for packet_assembler: fixed headers, hand-computed output beats,
// each beat compared as {valid, sop, eop, byte_enable, packet, error, ready}.
module tb_packet_assembler;

    logic        iClk;
    logic        iReset_n;
    logic [55:0] iHeaders;
    logic [63:0] iPayload;
    logic        iPayload_valid;
    logic        iSop;
    logic        iEop;
    logic [7:0]  iByte_enable;
    logic        oPayload_ready;
    logic        oValid;
    logic [63:0] oPacket;
    logic        oSop;
    logic        oEop;
    logic [7:0]  oByte_enable;
    logic        oError;

    int checks   = 0;
    int failures = 0;

    logic [76:0] got;
    logic [76:0] want;

    packet_assembler dut (
        .iClk          (iClk),
        .iReset_n      (iReset_n),
        .iHeaders      (iHeaders),
        .iPayload      (iPayload),
        .iPayload_valid(iPayload_valid),
        .iSop          (iSop),
        .iEop          (iEop),
        .iByte_enable  (iByte_enable),
        .oPayload_ready(oPayload_ready),
        .oValid        (oValid),
        .oPacket       (oPacket),
        .oSop          (oSop),
        .oEop          (oEop),
        .oByte_enable  (oByte_enable),
        .oError        (oError)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    function automatic logic [76:0] obs();
        return {oValid, oSop, oEop, oByte_enable, oPacket, oError, oPayload_ready};
    endfunction

    function automatic logic [76:0] beat(input logic v, input logic s, input logic e,
                                         input logic [7:0] be, input logic [63:0] d,
                                         input logic err, input logic rdy);
        return {v, s, e, be, d, err, rdy};
    endfunction

    // Present one input beat, clock it, and leave the outputs settled 1 time unit later.
    task automatic drive(input logic v, input logic s, input logic e,
                         input logic [7:0] be, input logic [63:0] d);
        iPayload_valid = v;
        iSop           = s;
        iEop           = e;
        iByte_enable   = be;
        iPayload       = d;
        @(posedge iClk);
        #1;
    endtask

    task automatic test_reset();
        iReset_n = 1'b0;
        drive(1, 1, 1, 8'hF8, 64'hA0A1A2A3A4000000);
        got = obs(); want = '0;
        if (got !== want) begin failures++; $display("FAIL reset_hold got=%h exp=%h", got, want); end
        checks++;
        drive(1, 1, 0, 8'hFF, 64'h0001020304050607);
        got = obs(); want = '0;
        if (got !== want) begin failures++; $display("FAIL reset_hold2 got=%h exp=%h", got, want); end
        checks++;
        iReset_n = 1'b1;
        drive(0, 0, 0, 8'h00, 64'h0);
        got = obs(); want = beat(0, 0, 0, 8'h00, 64'h0, 0, 1);
        if (got !== want) begin failures++; $display("FAIL reset_release got=%h exp=%h", got, want); end
        checks++;
    endtask

    task automatic test_five_byte(input string tag);
        drive(1, 1, 1, 8'hF8, 64'hA0A1A2A3A4000000);
        got = obs(); want = beat(1, 1, 0, 8'hFF, 64'h11223344556677A0, 0, 0);
        if (got !== want) begin failures++; $display("FAIL %s_beat1 got=%h exp=%h", tag, got, want); end
        checks++;
        drive(0, 0, 0, 8'h00, 64'h0);
        got = obs(); want = beat(1, 0, 1, 8'hF0, 64'hA1A2A3A400000000, 0, 1);
        if (got !== want) begin failures++; $display("FAIL %s_tail got=%h exp=%h", tag, got, want); end
        checks++;
        drive(0, 0, 0, 8'h00, 64'h0);
        got = obs(); want = beat(0, 0, 0, 8'h00, 64'h0, 0, 1);
        if (got !== want) begin failures++; $display("FAIL %s_idle got=%h exp=%h", tag, got, want); end
        checks++;
    endtask

    task automatic test_one_byte();
        drive(1, 1, 1, 8'h80, 64'hB0FFFFFFFFFFFFFF);
        got = obs(); want = beat(1, 1, 1, 8'hFF, 64'h11223344556677B0, 0, 1);
        if (got !== want) begin failures++; $display("FAIL one_byte got=%h exp=%h", got, want); end
        checks++;
        drive(0, 0, 0, 8'h00, 64'h0);
        got = obs(); want = beat(0, 0, 0, 8'h00, 64'h0, 0, 1);
        if (got !== want) begin failures++; $display("FAIL one_byte_idle got=%h exp=%h", got, want); end
        checks++;
    endtask

    task automatic test_sixteen_byte_gap();
        drive(1, 1, 0, 8'hFF, 64'h0001020304050607);
        got = obs(); want = beat(1, 1, 0, 8'hFF, 64'h1122334455667700, 0, 1);
        if (got !== want) begin failures++; $display("FAIL b16_beat1 got=%h exp=%h", got, want); end
        checks++;
        drive(0, 1, 1, 8'h00, 64'hDEADBEEFDEADBEEF);
        got = obs(); want = beat(0, 0, 0, 8'h00, 64'h0, 0, 1);
        if (got !== want) begin failures++; $display("FAIL b16_gap got=%h exp=%h", got, want); end
        checks++;
        drive(1, 0, 1, 8'hFF, 64'h08090A0B0C0D0E0F);
        got = obs(); want = beat(1, 0, 0, 8'hFF, 64'h0102030405060708, 0, 0);
        if (got !== want) begin failures++; $display("FAIL b16_beat2 got=%h exp=%h", got, want); end
        checks++;
        drive(0, 0, 0, 8'h00, 64'h0);
        got = obs(); want = beat(1, 0, 1, 8'hFE, 64'h090A0B0C0D0E0F00, 0, 1);
        if (got !== want) begin failures++; $display("FAIL b16_tail got=%h exp=%h", got, want); end
        checks++;
    endtask

    task automatic test_back_to_back();
        drive(1, 1, 1, 8'hF8, 64'hA0A1A2A3A4000000);
        got = obs(); want = beat(1, 1, 0, 8'hFF, 64'h11223344556677A0, 0, 0);
        if (got !== want) begin failures++; $display("FAIL b2b_a_beat1 got=%h exp=%h", got, want); end
        checks++;
        // Next packet already waiting; it must stall through the flush beat.
        drive(1, 1, 1, 8'h80, 64'hB000000000000000);
        got = obs(); want = beat(1, 0, 1, 8'hF0, 64'hA1A2A3A400000000, 0, 1);
        if (got !== want) begin failures++; $display("FAIL b2b_a_tail got=%h exp=%h", got, want); end
        checks++;
        drive(1, 1, 1, 8'h80, 64'hB000000000000000);
        got = obs(); want = beat(1, 1, 1, 8'hFF, 64'h11223344556677B0, 0, 1);
        if (got !== want) begin failures++; $display("FAIL b2b_b got=%h exp=%h", got, want); end
        checks++;
        drive(1, 1, 0, 8'hFF, 64'hC0C1C2C3C4C5C6C7);
        got = obs(); want = beat(1, 1, 0, 8'hFF, 64'h11223344556677C0, 0, 1);
        if (got !== want) begin failures++; $display("FAIL b2b_c_beat1 got=%h exp=%h", got, want); end
        checks++;
        drive(1, 0, 1, 8'h80, 64'hC8EEEEEEEEEEEEEE);
        got = obs(); want = beat(1, 0, 1, 8'hFF, 64'hC1C2C3C4C5C6C7C8, 0, 1);
        if (got !== want) begin failures++; $display("FAIL b2b_c_beat2 got=%h exp=%h", got, want); end
        checks++;
        drive(0, 0, 0, 8'h00, 64'h0);
        got = obs(); want = beat(0, 0, 0, 8'h00, 64'h0, 0, 1);
        if (got !== want) begin failures++; $display("FAIL b2b_idle got=%h exp=%h", got, want); end
        checks++;
    endtask

    task automatic test_errors();
        drive(1, 0, 0, 8'hFF, 64'hDEADBEEFCAFEF00D);
        got = obs(); want = beat(0, 0, 0, 8'h00, 64'h0, 1, 1);
        if (got !== want) begin failures++; $display("FAIL err_nosop got=%h exp=%h", got, want); end
        checks++;
        drive(0, 0, 0, 8'h00, 64'h0);
        got = obs(); want = beat(0, 0, 0, 8'h00, 64'h0, 0, 1);
        if (got !== want) begin failures++; $display("FAIL err_pulse_end got=%h exp=%h", got, want); end
        checks++;
        drive(1, 1, 0, 8'hFF, 64'h0001020304050607);
        got = obs(); want = beat(1, 1, 0, 8'hFF, 64'h1122334455667700, 0, 1);
        if (got !== want) begin failures++; $display("FAIL err_open got=%h exp=%h", got, want); end
        checks++;
        drive(1, 1, 1, 8'h80, 64'hB000000000000000);
        got = obs(); want = beat(1, 1, 1, 8'hFF, 64'h11223344556677B0, 1, 1);
        if (got !== want) begin failures++; $display("FAIL err_sop_mid got=%h exp=%h", got, want); end
        checks++;
        drive(1, 1, 1, 8'h00, 64'hE0E1E2E3E4E5E6E7);
        got = obs(); want = beat(1, 1, 1, 8'hFF, 64'h11223344556677E0, 1, 1);
        if (got !== want) begin failures++; $display("FAIL err_zero_be got=%h exp=%h", got, want); end
        checks++;
        drive(1, 1, 1, 8'hB0, 64'hD0D1D2D3D4D5D6D7);
        got = obs(); want = beat(1, 1, 1, 8'hFF, 64'h11223344556677D0, 0, 1);
        if (got !== want) begin failures++; $display("FAIL noncontig_be got=%h exp=%h", got, want); end
        checks++;
        drive(0, 0, 0, 8'h00, 64'h0);
    endtask

    task automatic test_reset_in_tail();
        drive(1, 1, 1, 8'hF8, 64'hA0A1A2A3A4000000);
        got = obs(); want = beat(1, 1, 0, 8'hFF, 64'h11223344556677A0, 0, 0);
        if (got !== want) begin failures++; $display("FAIL rst_tail_beat1 got=%h exp=%h", got, want); end
        checks++;
        iReset_n = 1'b0;
        drive(0, 0, 0, 8'h00, 64'h0);
        got = obs(); want = '0;
        if (got !== want) begin failures++; $display("FAIL rst_tail_cleared got=%h exp=%h", got, want); end
        checks++;
        iReset_n = 1'b1;
        drive(0, 0, 0, 8'h00, 64'h0);
        got = obs(); want = beat(0, 0, 0, 8'h00, 64'h0, 0, 1);
        if (got !== want) begin failures++; $display("FAIL rst_tail_release got=%h exp=%h", got, want); end
        checks++;
        test_five_byte("rst_again");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        iHeaders       = 56'h11223344556677;
        iReset_n       = 1'b0;
        iPayload_valid = 1'b0;
        iSop           = 1'b0;
        iEop           = 1'b0;
        iByte_enable   = 8'h00;
        iPayload       = 64'h0;
        @(negedge iClk);
        test_reset();
        test_five_byte("b5");
        test_one_byte();
        test_sixteen_byte_gap();
        test_back_to_back();
        test_errors();
        test_reset_in_tail();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
